// File: rtl/ama_riscv_mem_pkg.sv
// Shared memory-arbiter types: read-ownership tags and memory geometry.
package ama_riscv_mem_pkg;

    localparam int CORE_ADDR_BUS_W = 14;
    localparam int MEM_SIZE_W      = 16384;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } mem_owner_t;

    typedef struct packed {
        logic       vld;
        mem_owner_t owner;
    } mem_tag_t;

    localparam mem_tag_t TAG_NONE = '{vld: 1'b0, owner: OWN_IF};

    function automatic mem_tag_t mk_tag(input logic vld, input mem_owner_t owner);
        mem_tag_t t;
        t.vld   = vld;
        t.owner = owner;
        return t;
    endfunction

endpackage

// File: rtl/ama_riscv_mem_arb_if.sv
// Bundle of fetch, load/store and memory-macro signals around the shared memory arbiter.
interface ama_riscv_mem_arb_if
    import ama_riscv_mem_pkg::*;
#(
    parameter int AW = CORE_ADDR_BUS_W
);

    logic          if_req_valid;
    logic          if_req_ready;
    logic [AW-1:0] if_req_addr;
    logic          if_rsp_valid;
    logic [31:0]   if_rsp_data;

    logic          ls_req_valid;
    logic          ls_req_ready;
    logic          ls_req_we;
    logic [3:0]    ls_req_wmask;
    logic [AW-1:0] ls_req_addr;
    logic [31:0]   ls_req_wdata;
    logic          ls_rsp_valid;
    logic [31:0]   ls_rsp_data;

    logic          mem_en;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    // Arbiter side.
    modport slave (
        input  if_req_valid, if_req_addr,
        input  ls_req_valid, ls_req_we, ls_req_wmask, ls_req_addr, ls_req_wdata,
        input  mem_rdata,
        output if_req_ready, if_rsp_valid, if_rsp_data,
        output ls_req_ready, ls_rsp_valid, ls_rsp_data,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    // Core requesters plus memory macro side.
    modport master (
        output if_req_valid, if_req_addr,
        output ls_req_valid, ls_req_we, ls_req_wmask, ls_req_addr, ls_req_wdata,
        output mem_rdata,
        input  if_req_ready, if_rsp_valid, if_rsp_data,
        input  ls_req_ready, ls_rsp_valid, ls_rsp_data,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/ama_riscv_mem_tag_pipe.sv
// Fixed-latency read-ownership pipeline: tracks each in-flight read and steers
// mem_rdata to the owning requester when the tag reaches the last stage.
`define AMA_MEM_TAG_STAGE(q, d) \
    always_ff @(posedge clk) begin \
        if (rst) begin \
            q <= TAG_NONE; \
        end else begin \
            q <= d; \
        end \
    end

module ama_riscv_mem_tag_pipe
    import ama_riscv_mem_pkg::*;
#(
    parameter int MEM_LAT = 1
)(
    input  logic        clk,
    input  logic        rst,
    input  mem_tag_t    tag_in,
    input  logic [31:0] mem_rdata,
    output logic        if_rsp_valid,
    output logic [31:0] if_rsp_data,
    output logic        ls_rsp_valid,
    output logic [31:0] ls_rsp_data
);

    mem_tag_t [MEM_LAT-1:0] stage_q_s;
    mem_tag_t               last_s;

    for (genvar i = 0; i < MEM_LAT; i++) begin : g_stage
        mem_tag_t d_s;
        mem_tag_t q_r;

        if (i == 0) begin : g_first
            assign d_s = tag_in;
        end else begin : g_next
            assign d_s = stage_q_s[i-1];
        end

        // One tag stage; reset drops every in-flight read.
        `AMA_MEM_TAG_STAGE(q_r, d_s)

        assign stage_q_s[i] = q_r;
    end

    assign last_s = stage_q_s[MEM_LAT-1];

    // Response demux; gated by rst so a read landing in the reset cycle is discarded too.
    always_comb begin
        if_rsp_valid = 1'b0;
        if_rsp_data  = 32'h0000_0000;
        ls_rsp_valid = 1'b0;
        ls_rsp_data  = 32'h0000_0000;
        if (!rst && last_s.vld) begin
            case (last_s.owner)
                OWN_IF: begin
                    if_rsp_valid = 1'b1;
                    if_rsp_data  = mem_rdata;
                end
                OWN_LS: begin
                    ls_rsp_valid = 1'b1;
                    ls_rsp_data  = mem_rdata;
                end
                default: begin
                    if_rsp_valid = 1'b0;
                    ls_rsp_valid = 1'b0;
                end
            endcase
        end else begin
            if_rsp_valid = 1'b0;
            ls_rsp_valid = 1'b0;
        end
    end

endmodule

`undef AMA_MEM_TAG_STAGE

// File: rtl/ama_riscv_mem_arb.sv
// Fetch vs load/store arbiter for one shared single-port memory, with fetch
// starvation guard. Optional perf counters: AMA_RISCV_ARB_PERF_CNT_EN.
module ama_riscv_mem_arb
    import ama_riscv_mem_pkg::*;
#(
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4,
    parameter int AW         = CORE_ADDR_BUS_W
)(
    input  logic               clk,
    input  logic               rst,
    ama_riscv_mem_arb_if.slave bus
`ifdef AMA_RISCV_ARB_PERF_CNT_EN
    ,
    output logic [31:0]        perf_conflict,
    output logic [31:0]        perf_starve_force
`endif
);

    localparam int            SW         = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    logic          if_gnt_s;
    logic          ls_gnt_s;
    logic          force_if_s;
    logic          both_vld_s;
    logic [SW-1:0] starve_cnt_r;

    logic          mem_en_s;
    logic [3:0]    mem_we_s;
    logic [AW-1:0] mem_addr_s;
    logic [31:0]   mem_wdata_s;
    mem_tag_t      tag_in_s;

    assign both_vld_s = bus.if_req_valid && bus.ls_req_valid;

    // Grant: load/store has priority unless fetch has lost STARVE_MAX times in a row.
    always_comb begin
        if_gnt_s   = 1'b0;
        ls_gnt_s   = 1'b0;
        force_if_s = 1'b0;
        if (rst) begin
            if_gnt_s = 1'b0;
            ls_gnt_s = 1'b0;
        end else if (both_vld_s) begin
            if (starve_cnt_r == STARVE_LIM) begin
                if_gnt_s   = 1'b1;
                force_if_s = 1'b1;
            end else begin
                ls_gnt_s = 1'b1;
            end
        end else if (bus.if_req_valid) begin
            if_gnt_s = 1'b1;
        end else if (bus.ls_req_valid) begin
            ls_gnt_s = 1'b1;
        end else begin
            if_gnt_s = 1'b0;
            ls_gnt_s = 1'b0;
        end
    end

    // Starvation counter: counts consecutive fetch losses, saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_r <= '0;
        end else if (bus.if_req_valid && ls_gnt_s) begin
            if (starve_cnt_r != STARVE_LIM) begin
                starve_cnt_r <= starve_cnt_r + SW'(1'b1);
            end else begin
                starve_cnt_r <= starve_cnt_r;
            end
        end else begin
            starve_cnt_r <= '0;
        end
    end

    // Winner drives the memory port; write strobes and data only for stores.
    always_comb begin
        mem_en_s    = 1'b0;
        mem_we_s    = 4'b0000;
        mem_addr_s  = '0;
        mem_wdata_s = 32'h0000_0000;
        if (ls_gnt_s) begin
            mem_en_s   = 1'b1;
            mem_addr_s = bus.ls_req_addr;
            if (bus.ls_req_we) begin
                mem_we_s    = bus.ls_req_wmask;
                mem_wdata_s = bus.ls_req_wdata;
            end else begin
                mem_we_s    = 4'b0000;
                mem_wdata_s = 32'h0000_0000;
            end
        end else if (if_gnt_s) begin
            mem_en_s   = 1'b1;
            mem_addr_s = bus.if_req_addr;
        end else begin
            mem_en_s = 1'b0;
        end
    end

    // Only reads enter the tag pipeline.
    always_comb begin
        tag_in_s = TAG_NONE;
        if (if_gnt_s) begin
            tag_in_s = mk_tag(1'b1, OWN_IF);
        end else if (ls_gnt_s && !bus.ls_req_we) begin
            tag_in_s = mk_tag(1'b1, OWN_LS);
        end else begin
            tag_in_s = TAG_NONE;
        end
    end

    assign bus.if_req_ready = if_gnt_s;
    assign bus.ls_req_ready = ls_gnt_s;
    assign bus.mem_en       = mem_en_s;
    assign bus.mem_we       = mem_we_s;
    assign bus.mem_addr     = mem_addr_s;
    assign bus.mem_wdata    = mem_wdata_s;

    ama_riscv_mem_tag_pipe #(
        .MEM_LAT (MEM_LAT)
    ) u_tag_pipe (
        .clk          (clk),
        .rst          (rst),
        .tag_in       (tag_in_s),
        .mem_rdata    (bus.mem_rdata),
        .if_rsp_valid (bus.if_rsp_valid),
        .if_rsp_data  (bus.if_rsp_data),
        .ls_rsp_valid (bus.ls_rsp_valid),
        .ls_rsp_data  (bus.ls_rsp_data)
    );

`ifdef AMA_RISCV_ARB_PERF_CNT_EN
    // Conflict cycles and forced fetch wins, free-running modulo 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_conflict     <= 32'd0;
            perf_starve_force <= 32'd0;
        end else begin
            perf_conflict     <= perf_conflict + (both_vld_s ? 32'd1 : 32'd0);
            perf_starve_force <= perf_starve_force + (force_if_s ? 32'd1 : 32'd0);
        end
    end
`endif

endmodule

// File: tb/tb_ama_riscv_mem_arb.sv
// Directed bench: one arbiter at MEM_LAT=1 and one at MEM_LAT=2, each with a write-first memory model.
module tb_ama_riscv_mem_arb;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_err;

    ama_riscv_mem_arb_if ifc1 ();
    ama_riscv_mem_arb_if ifc2 ();

`ifdef AMA_RISCV_ARB_PERF_CNT_EN
    logic [31:0] perf_c1, perf_f1, perf_c2, perf_f2;
`endif

    ama_riscv_mem_arb #(.MEM_LAT(1), .STARVE_MAX(4)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (ifc1.slave)
`ifdef AMA_RISCV_ARB_PERF_CNT_EN
        ,
        .perf_conflict     (perf_c1),
        .perf_starve_force (perf_f1)
`endif
    );

    ama_riscv_mem_arb #(.MEM_LAT(2), .STARVE_MAX(4)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (ifc2.slave)
`ifdef AMA_RISCV_ARB_PERF_CNT_EN
        ,
        .perf_conflict     (perf_c2),
        .perf_starve_force (perf_f2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models with a preload backdoor
    logic [31:0] mem1 [16384];
    logic [31:0] mem2 [16384];
    logic [31:0] rd1, rd2a, rd2b;
    logic        pl_en, pl_sel;
    logic [13:0] pl_a;
    logic [31:0] pl_d;

    always @(posedge clk) begin
        if (pl_en && !pl_sel) begin
            mem1[pl_a] <= pl_d;
        end else if (ifc1.mem_en) begin
            if (ifc1.mem_we != 4'b0000) begin
                for (int b = 0; b < 4; b++)
                    if (ifc1.mem_we[b]) mem1[ifc1.mem_addr][b*8 +: 8] <= ifc1.mem_wdata[b*8 +: 8];
            end else begin
                rd1 <= mem1[ifc1.mem_addr];
            end
        end
    end

    always @(posedge clk) begin
        if (pl_en && pl_sel) begin
            mem2[pl_a] <= pl_d;
        end else if (ifc2.mem_en) begin
            if (ifc2.mem_we != 4'b0000) begin
                for (int b = 0; b < 4; b++)
                    if (ifc2.mem_we[b]) mem2[ifc2.mem_addr][b*8 +: 8] <= ifc2.mem_wdata[b*8 +: 8];
            end else begin
                rd2a <= mem2[ifc2.mem_addr];
            end
        end
        rd2b <= rd2a;
    end

    assign ifc1.mem_rdata = rd1;
    assign ifc2.mem_rdata = rd2b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic pl(input logic sel, input logic [13:0] a, input logic [31:0] d);
        pl_sel = sel;
        pl_a   = a;
        pl_d   = d;
        pl_en  = 1'b1;
        nxt();
        pl_en  = 1'b0;
    endtask

    task automatic idle_all();
        ifc1.if_req_valid = 1'b0; ifc1.if_req_addr = 14'h0;
        ifc1.ls_req_valid = 1'b0; ifc1.ls_req_we = 1'b0; ifc1.ls_req_wmask = 4'h0;
        ifc1.ls_req_addr  = 14'h0; ifc1.ls_req_wdata = 32'h0;
        ifc2.if_req_valid = 1'b0; ifc2.if_req_addr = 14'h0;
        ifc2.ls_req_valid = 1'b0; ifc2.ls_req_we = 1'b0; ifc2.ls_req_wmask = 4'h0;
        ifc2.ls_req_addr  = 14'h0; ifc2.ls_req_wdata = 32'h0;
    endtask

    initial begin
        logic exp_if;
        logic prev_if;
        n_checks = 0;
        n_err    = 0;
        rst      = 1'b1;
        pl_en    = 1'b0;
        pl_sel   = 1'b0;
        pl_a     = 14'h0;
        pl_d     = 32'h0;
        idle_all();

        pl(1'b0, 14'h010, 32'h0000_000A);
        pl(1'b0, 14'h011, 32'h0000_000B);
        pl(1'b0, 14'h020, 32'h0000_0200);
        pl(1'b0, 14'h030, 32'h0000_0300);
        pl(1'b0, 14'h005, 32'h1122_3344);
        pl(1'b1, 14'h001, 32'h0000_0111);
        pl(1'b1, 14'h002, 32'h0000_0222);
        pl(1'b1, 14'h003, 32'h0000_0333);

        // Reset state, with requests presented during reset
        ifc1.if_req_valid = 1'b1;
        ifc1.ls_req_valid = 1'b1;
        #1;
        chk("rst_if_rsp_v", 32'(ifc1.if_rsp_valid), 32'd0);
        chk("rst_if_rsp_d", ifc1.if_rsp_data, 32'd0);
        chk("rst_ls_rsp_v", 32'(ifc2.ls_rsp_valid), 32'd0);
        chk("rst_ls_rsp_d", ifc2.ls_rsp_data, 32'd0);
        chk("rst_if_rdy", 32'(ifc1.if_req_ready), 32'd0);
        chk("rst_ls_rdy", 32'(ifc1.ls_req_ready), 32'd0);
        chk("rst_mem_en", 32'(ifc1.mem_en), 32'd0);
        chk("rst_cnt", 32'(u_dut1.starve_cnt_r), 32'd0);

        // Fetch-only back-to-back reads, MEM_LAT=1
        nxt(); rst = 1'b0; idle_all();
        ifc1.if_req_valid = 1'b1; ifc1.if_req_addr = 14'h010;
        #1;
        chk("a0_if_rdy", 32'(ifc1.if_req_ready), 32'd1);
        chk("a0_mem_addr", 32'(ifc1.mem_addr), 32'h10);
        chk("a0_mem_we", 32'(ifc1.mem_we), 32'd0);
        nxt(); ifc1.if_req_addr = 14'h011;
        #1;
        chk("a1_if_rdy", 32'(ifc1.if_req_ready), 32'd1);
        chk("a1_if_rsp_v", 32'(ifc1.if_rsp_valid), 32'd1);
        chk("a1_if_rsp_d", ifc1.if_rsp_data, 32'h0000_000A);
        chk("a1_ls_rsp_v", 32'(ifc1.ls_rsp_valid), 32'd0);
        nxt(); ifc1.if_req_valid = 1'b0;
        #1;
        chk("a2_if_rsp_v", 32'(ifc1.if_rsp_valid), 32'd1);
        chk("a2_if_rsp_d", ifc1.if_rsp_data, 32'h0000_000B);
        chk("a2_ls_rsp_v", 32'(ifc1.ls_rsp_valid), 32'd0);
        chk("a2_mem_en", 32'(ifc1.mem_en), 32'd0);
        nxt();
        #1;
        chk("a3_if_rsp_v", 32'(ifc1.if_rsp_valid), 32'd0);

        // Both requesting loads continuously: LS,LS,LS,LS,IF repeating
        prev_if = 1'b0;
        for (int k = 0; k < 10; k++) begin
            nxt();
            if (k == 0) begin
                ifc1.if_req_valid = 1'b1; ifc1.if_req_addr = 14'h020;
                ifc1.ls_req_valid = 1'b1; ifc1.ls_req_we = 1'b0; ifc1.ls_req_addr = 14'h030;
                ifc1.ls_req_wmask = 4'hF; ifc1.ls_req_wdata = 32'hFFFF_FFFF;
            end
            #1;
            exp_if = (k % 5 == 4);
            chk("b_if_rdy", 32'(ifc1.if_req_ready), 32'(exp_if));
            chk("b_ls_rdy", 32'(ifc1.ls_req_ready), 32'(!exp_if));
            chk("b_mem_addr", 32'(ifc1.mem_addr), exp_if ? 32'h20 : 32'h30);
            chk("b_mem_we", 32'(ifc1.mem_we), 32'd0);
            chk("b_mem_wdata", ifc1.mem_wdata, 32'd0);
            if (k > 0) begin
                chk("b_if_rsp_v", 32'(ifc1.if_rsp_valid), 32'(prev_if));
                chk("b_ls_rsp_v", 32'(ifc1.ls_rsp_valid), 32'(!prev_if));
                chk("b_if_rsp_d", ifc1.if_rsp_data, prev_if ? 32'h200 : 32'h0);
                chk("b_ls_rsp_d", ifc1.ls_rsp_data, prev_if ? 32'h0 : 32'h300);
            end
            prev_if = exp_if;
        end
        nxt(); idle_all();
        #1;
        chk("b_last_if_rsp_v", 32'(ifc1.if_rsp_valid), 32'd1);
        chk("b_last_if_rsp_d", ifc1.if_rsp_data, 32'h200);
`ifdef AMA_RISCV_ARB_PERF_CNT_EN
        chk("b_perf_force", perf_f1, 32'd2);
        chk("b_perf_conflict", perf_c1, 32'd10);
`endif

        // Partial store then fetch of the same word
        nxt();
        ifc1.ls_req_valid = 1'b1; ifc1.ls_req_we = 1'b1; ifc1.ls_req_wmask = 4'b0011;
        ifc1.ls_req_addr  = 14'h005; ifc1.ls_req_wdata = 32'hDEAD_BEEF;
        #1;
        chk("c0_ls_rdy", 32'(ifc1.ls_req_ready), 32'd1);
        chk("c0_mem_we", 32'(ifc1.mem_we), 32'b0011);
        chk("c0_mem_wdata", ifc1.mem_wdata, 32'hDEAD_BEEF);
        chk("c0_mem_addr", 32'(ifc1.mem_addr), 32'h5);
        nxt(); idle_all();
        ifc1.if_req_valid = 1'b1; ifc1.if_req_addr = 14'h005;
        #1;
        chk("c1_if_rdy", 32'(ifc1.if_req_ready), 32'd1);
        chk("c1_ls_rsp_v", 32'(ifc1.ls_rsp_valid), 32'd0);
        nxt(); idle_all();
        #1;
        chk("c2_if_rsp_v", 32'(ifc1.if_rsp_valid), 32'd1);
        chk("c2_if_rsp_d", ifc1.if_rsp_data, 32'h1122_BEEF);
        chk("c2_ls_rsp_v", 32'(ifc1.ls_rsp_valid), 32'd0);

        // MEM_LAT=2 interleaved IF/LS/IF reads
        nxt(); ifc2.if_req_valid = 1'b1; ifc2.if_req_addr = 14'h001;
        #1;
        chk("d0_if_rdy", 32'(ifc2.if_req_ready), 32'd1);
        nxt(); idle_all();
        ifc2.ls_req_valid = 1'b1; ifc2.ls_req_addr = 14'h002;
        #1;
        chk("d1_ls_rdy", 32'(ifc2.ls_req_ready), 32'd1);
        chk("d1_if_rsp_v", 32'(ifc2.if_rsp_valid), 32'd0);
        nxt(); idle_all();
        ifc2.if_req_valid = 1'b1; ifc2.if_req_addr = 14'h003;
        #1;
        chk("d2_if_rdy", 32'(ifc2.if_req_ready), 32'd1);
        chk("d2_if_rsp_v", 32'(ifc2.if_rsp_valid), 32'd1);
        chk("d2_if_rsp_d", ifc2.if_rsp_data, 32'h111);
        chk("d2_ls_rsp_v", 32'(ifc2.ls_rsp_valid), 32'd0);
        nxt(); idle_all();
        #1;
        chk("d3_ls_rsp_v", 32'(ifc2.ls_rsp_valid), 32'd1);
        chk("d3_ls_rsp_d", ifc2.ls_rsp_data, 32'h222);
        chk("d3_if_rsp_v", 32'(ifc2.if_rsp_valid), 32'd0);
        chk("d3_if_rsp_d", ifc2.if_rsp_data, 32'h0);
        nxt();
        #1;
        chk("d4_if_rsp_v", 32'(ifc2.if_rsp_valid), 32'd1);
        chk("d4_if_rsp_d", ifc2.if_rsp_data, 32'h333);
        nxt();
        #1;
        chk("d5_if_rsp_v", 32'(ifc2.if_rsp_valid), 32'd0);

        // Reset one cycle after a load grant, MEM_LAT=2
        nxt(); ifc2.ls_req_valid = 1'b1; ifc2.ls_req_addr = 14'h002;
        #1;
        chk("e0_ls_rdy", 32'(ifc2.ls_req_ready), 32'd1);
        nxt(); rst = 1'b1;
        ifc2.if_req_valid = 1'b1; ifc2.if_req_addr = 14'h001;
        #1;
        chk("e1_if_rdy", 32'(ifc2.if_req_ready), 32'd0);
        chk("e1_ls_rdy", 32'(ifc2.ls_req_ready), 32'd0);
        chk("e1_ls_rsp_v", 32'(ifc2.ls_rsp_valid), 32'd0);
        nxt(); rst = 1'b0; idle_all();
        #1;
        chk("e2_ls_rsp_v", 32'(ifc2.ls_rsp_valid), 32'd0);
        chk("e2_cnt", 32'(u_dut2.starve_cnt_r), 32'd0);
        nxt();
        #1;
        chk("e3_ls_rsp_v", 32'(ifc2.ls_rsp_valid), 32'd0);
        chk("e3_if_rsp_v", 32'(ifc2.if_rsp_valid), 32'd0);

        // Idle for five cycles
        for (int k = 0; k < 5; k++) begin
            nxt();
            #1;
            chk("f_mem_en1", 32'(ifc1.mem_en), 32'd0);
            chk("f_mem_we1", 32'(ifc1.mem_we), 32'd0);
            chk("f_mem_addr1", 32'(ifc1.mem_addr), 32'd0);
            chk("f_mem_en2", 32'(ifc2.mem_en), 32'd0);
            chk("f_rsp_v1", 32'({ifc1.if_rsp_valid, ifc1.ls_rsp_valid}), 32'd0);
            chk("f_rsp_v2", 32'({ifc2.if_rsp_valid, ifc2.ls_rsp_valid}), 32'd0);
            chk("f_cnt1", 32'(u_dut1.starve_cnt_r), 32'd0);
            chk("f_cnt2", 32'(u_dut2.starve_cnt_r), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/ama_riscv_mem_arb.md
Name: ama_riscv_mem_arb

Overview:
- Arbitrates one shared single-port synchronous memory (MEM_SIZE_W words, 32-bit) between the instruction-fetch requester and the load/store requester.
- Issues at most one access per cycle, with pipelined, fixed-latency reads.
- Tracks ownership of every in-flight read and routes read data back to the owning requester.
- Sits between the core (fetch and MEM stage) and the memory macro, in place of separate IMEM and DMEM ports.

Parameters:
MEM_LAT, 1, memory read latency in cycles (1 or 2; 2 mirrors the 2-cycle fetch delay configuration)
STARVE_MAX, 4, consecutive cycles fetch may lose arbitration before it is forced to win
AW, CORE_ADDR_BUS_W (14), word address width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
if_req_valid  in  1  fetch request
if_req_ready  out  1  fetch granted this cycle
if_req_addr  in  AW  fetch word address
if_rsp_valid  out  1  fetch read data valid
if_rsp_data  out  32  fetch read data
ls_req_valid  in  1  load/store request
ls_req_ready  out  1  load/store granted this cycle
ls_req_we  in  1  1 = store, 0 = load
ls_req_wmask  in  4  store byte enables
ls_req_addr  in  AW  load/store word address
ls_req_wdata  in  32  store data
ls_rsp_valid  out  1  load read data valid
ls_rsp_data  out  32  load read data
mem_en  out  1  memory access enable
mem_we  out  4  memory byte write enables
mem_addr  out  AW  memory address
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data, valid MEM_LAT cycles after mem_en with mem_we == 0

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Handshake:
  - A request transfers when valid && ready in the same cycle.
  - ready is combinational from the valids and the arbiter state.
  - Requesters hold valid, addr and data stable until ready.
  - The response path has no backpressure; requesters always accept a response.
- Arbitration, evaluated per cycle:
  - Only one requester valid: that requester wins.
  - Both valid: load/store wins, unless starve_cnt == STARVE_MAX, in which case fetch wins.
  - Winner's signals drive the mem_* outputs combinationally in the same cycle.
  - mem_en = granted valid.
  - mem_we = wmask when the granted access is a store, else 0.
  - mem_we and mem_wdata are 0 when the access is not a store.
- Starvation counter:
  - starve_cnt width is $clog2(STARVE_MAX+1).
  - Increments when both are valid and load/store wins.
  - Clears when fetch wins, or when if_req_valid == 0.
  - Saturates at STARVE_MAX.
- Tag pipeline:
  - Shift register of MEM_LAT entries, each entry {vld, owner}.
  - Stage 0 loads {granted read, owner}; stores load vld = 0.
  - The last stage asserts the owner's rsp_valid, with rsp_data = mem_rdata. The other rsp_data is 0.
  - Throughput: one read per cycle with no bubbles; read latency is exactly MEM_LAT cycles after the grant.
- Reset values: all tag entries invalid, starve_cnt = 0, both rsp_valid = 0, both rsp_data = 0.
- mem_* outputs follow the inputs combinationally; with both valids low, all mem_* outputs are 0.
- Reset mid-operation: in-flight reads are discarded and no response is produced for them. Requests presented while rst = 1 are not granted (both readys = 0).
- Same-address read after write:
  - Load/store wins both cycles, so program order is preserved.
  - A fetch granted on the cycle after a store to the same address sees the new data (memory write-first).

Optional Feature:
- Macro: AMA_RISCV_ARB_PERF_CNT_EN.
- Defined:
  - Adds output ports perf_conflict (32 bits) and perf_starve_force (32 bits).
  - perf_conflict counts cycles with both valids high.
  - perf_starve_force counts forced fetch wins.
  - Both reset to 0 and wrap modulo 2^32.
- Not defined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package ama_riscv_mem_pkg:
  - typedef enum logic {OWN_IF, OWN_LS} mem_owner_t
  - typedef struct packed {logic vld; mem_owner_t owner;} mem_tag_t
  - MEM_SIZE_W and CORE_ADDR_BUS_W move here
- Sub-module ama_riscv_mem_tag_pipe: MEM_LAT-deep mem_tag_t shift register (built with STAGE macros) plus response demux.
- Grant logic and starvation counter stay in the top.

Test Plan:
- MEM_LAT = 1, fetch only: read addr 0x10 then addr 0x11 on back-to-back cycles, mem holds 0xA/0xB → if_rsp_valid high 2 consecutive cycles with data 0xA then 0xB; ls_rsp_valid stays 0.
- Both valid continuously with loads, STARVE_MAX = 4 → grant pattern LS, LS, LS, LS, IF repeating; perf_starve_force = 2 after 10 cycles (macro defined).
- Store wmask 4'b0011, wdata 0xDEADBEEF to addr 5, then fetch addr 5 (old 0x11223344) → mem_we = 4'b0011; no ls response; fetch returns 0x1122BEEF.
- MEM_LAT = 2, interleaved IF read (addr 1), LS load (addr 2), IF read (addr 3) → responses at grant+2 routed to IF, LS, IF respectively, no bubbles.
- rst asserted 1 cycle after a load grant with MEM_LAT = 2 → ls_rsp_valid never asserts; both readys = 0 during rst; starve_cnt = 0 after release.
- No valids for 5 cycles → mem_en = 0, mem_we = 0, no rsp_valid, starve_cnt stays 0.
